// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if
// Sample-side handshake between the volume-scaling stage and the I2S
// transmitter.
//   aud_vld  : 1-clk strobe, lft_in/rht_in valid
//   lft_in   : signed left sample
//   rht_in   : signed right sample
//   frm_strt : 1-clk pulse from the transmitter at each frame boundary,
//              used upstream to pace sample production
// Modports: master = sample producer, slave = audio_i2s_tx.
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic              aud_vld;
    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rht_in;
    logic              frm_strt;

    modport master (
        output aud_vld,
        output lft_in,
        output rht_in,
        input  frm_strt
    );

    modport slave (
        input  aud_vld,
        input  lft_in,
        input  rht_in,
        output frm_strt
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// I2S transmitter: serialises signed left/right sample pairs to a codec DAC,
// generating bclk, lrclk and sdout from the system clock. One sample pair is
// held pending; at each frame boundary it moves into the frame registers that
// are being shifted out. If nothing is pending the last frame repeats.
//
// Ports:
//   clk   : system clock
//   rst   : asynchronous reset, active-high
//   aud   : audio_i2s_tx_if.slave (aud_vld, lft_in, rht_in in; frm_strt out)
//   udf   : 1-clk pulse, frame boundary with no pending sample
//   ovr   : 1-clk pulse, pending sample overwritten before use
//   bclk  : I2S bit clock
//   lrclk : I2S word select, 0 = left, 1 = right
//   sdout : I2S serial data, MSB first, one bclk after the lrclk edge
//
// Build option:
//   MUTE_ON_UDF_EN : when defined, an underflow boundary loads zeros into the
//                    frame registers instead of repeating the last pair.
module audio_i2s_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32,
    parameter int DATA_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    audio_i2s_tx_if.slave  aud,
    output logic           udf,
    output logic           ovr,
    output logic           bclk,
    output logic           lrclk,
    output logic           sdout
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_B   = BIT_W'(DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] pend_lft;
    logic [DATA_W-1:0] pend_rht;
    logic              pend_full;
    logic [DATA_W-1:0] frame_lft;
    logic [DATA_W-1:0] frame_rht;
    logic              frame0_done;

    logic              fall;
    logic              boundary;
    logic              load;
    logic              underrun;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_next;
    logic              right_next;
    logic [BIT_W-1:0]  pos_next;
    logic [DATA_W-1:0] sample_next;
    logic [IDX_W-1:0]  sample_idx;
    logic              sdout_next;

    // Timing decode: the divider wrap is the bclk falling edge, and the
    // fall on the last bit of the frame is the frame boundary. Next-state
    // bit position is decoded here so lrclk/sdout can be registered on the
    // same edge that bit_cnt advances.
    always_comb begin
        fall        = (div_cnt == DIV_LAST);
        div_next    = fall ? '0 : div_cnt + 1'b1;
        boundary    = fall && (bit_cnt == BIT_LAST);
        load        = boundary && pend_full;
        underrun    = boundary && !pend_full;
        bit_next    = bit_cnt;
        if (fall) begin
            bit_next = boundary ? '0 : bit_cnt + 1'b1;
        end
        right_next  = (bit_next >= SLOT_B);
        pos_next    = right_next ? (bit_next - SLOT_B) : bit_next;
        sample_next = right_next ? frame_rht : frame_lft;
        sample_idx  = IDX_W'(DATA_W - int'(pos_next));
        sdout_next  = 1'b0;
        // Slot position 0 is the I2S one-bclk delay; MSB goes out at 1.
        if ((pos_next != '0) && (pos_next <= DATA_B)) begin
            sdout_next = sample_next[sample_idx];
        end
    end

    // Bit-clock generation and serial outputs. bclk is high for the upper
    // half of the divider count; lrclk/sdout change only on the falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            sdout   <= 1'b0;
        end else begin
            div_cnt <= div_next;
            bclk    <= (div_next >= DIV_HALF);
            if (fall) begin
                bit_cnt <= bit_next;
                lrclk   <= right_next;
                sdout   <= sdout_next;
            end
        end
    end

    // Sample buffering. A new pair always becomes pending; a pair arriving
    // on the boundary edge lands in pending while the old one is loaded, so
    // it is not an overrun. Frame 0 after reset is silence and its end is
    // never reported as an underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_lft     <= '0;
            pend_rht     <= '0;
            pend_full    <= 1'b0;
            frame_lft    <= '0;
            frame_rht    <= '0;
            frame0_done  <= 1'b0;
            aud.frm_strt <= 1'b0;
            udf          <= 1'b0;
            ovr          <= 1'b0;
        end else begin
            if (aud.aud_vld) begin
                pend_lft <= aud.lft_in;
                pend_rht <= aud.rht_in;
            end
            pend_full <= aud.aud_vld || (pend_full && !load);
            if (load) begin
                frame_lft <= pend_lft;
                frame_rht <= pend_rht;
            end
`ifdef MUTE_ON_UDF_EN
            else if (underrun) begin
                frame_lft <= '0;
                frame_rht <= '0;
            end
`endif
            if (boundary) begin
                frame0_done <= 1'b1;
            end
            aud.frm_strt <= boundary;
            udf          <= underrun && frame0_done;
            ovr          <= aud.aud_vld && pend_full && !load;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx
// Scoreboard bench for audio_i2s_tx at default parameters. The stimulus
// process plans each frame window (which pairs arrive and when), derives the
// frame that the following boundary must transmit, and queues the expected
// frame data, underflow flag and overrun count. A monitor decodes sdout at
// each bclk rise, reassembles each frame and compares at every frm_strt.
// Honours MUTE_ON_UDF_EN in its reference model.
module tb_audio_i2s_tx;

    localparam int FRAME_CLK = 256;
    localparam int FRAME_BITS = 64;

    logic clk;
    logic rst;
    logic udf;
    logic ovr;
    logic bclk;
    logic lrclk;
    logic sdout;

    audio_i2s_tx_if #(.DATA_W(16)) aud ();

    audio_i2s_tx #(
        .BCLK_DIV (4),
        .SLOT_BITS(32),
        .DATA_W   (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .aud  (aud),
        .udf  (udf),
        .ovr  (ovr),
        .bclk (bclk),
        .lrclk(lrclk),
        .sdout(sdout)
    );

    int n_vec = 0;
    int n_fail = 0;

    logic [31:0] data_q[$];
    bit          udf_q[$];
    int          ovr_q[$];
    logic [31:0] model_prev;

    logic [31:0] edge_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last reset release; frame boundaries fall on
    // multiples of FRAME_CLK.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= '0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check_output(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: reassemble frames from sdout at bclk rises and compare with
    // the scoreboard at each frame boundary.
    logic        bits[FRAME_BITS];
    int          bit_idx;
    logic        bclk_q;
    int          ovr_seen;
    int          frame_no;

    always @(negedge clk) begin
        if (rst) begin
            bit_idx  = 0;
            bclk_q   = 1'b0;
            ovr_seen = 0;
            frame_no = 0;
        end else begin
            if (bclk && !bclk_q) begin
                if (bit_idx < FRAME_BITS) begin
                    bits[bit_idx] = sdout;
                    check_output("lrclk", {31'b0, lrclk}, {31'b0, (bit_idx >= 32)});
                end
                bit_idx++;
            end
            bclk_q = bclk;
            if (ovr) ovr_seen++;
            if (udf && !aud.frm_strt) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL udf_stray: got 1, expected 0 at %0t", $time);
            end
            if (aud.frm_strt) begin
                logic [15:0] got_l;
                logic [15:0] got_r;
                logic        extra;
                frame_no++;
                check_output("frm_period", edge_cnt, FRAME_CLK * frame_no);
                check_output("frame_bits", bit_idx, FRAME_BITS);
                got_l = '0;
                got_r = '0;
                extra = 1'b0;
                for (int i = 0; i < FRAME_BITS; i++) begin
                    if (i >= 1 && i <= 16)       got_l = {got_l[14:0], bits[i]};
                    else if (i >= 33 && i <= 48) got_r = {got_r[14:0], bits[i]};
                    else                         extra = extra | bits[i];
                end
                if (data_q.size() == 0 || udf_q.size() == 0 || ovr_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL scoreboard_empty: got frame %0d, expected none", frame_no);
                end else begin
                    logic [31:0] exp_d;
                    exp_d = data_q.pop_front();
                    check_output("left_word", {16'b0, got_l}, {16'b0, exp_d[31:16]});
                    check_output("right_word", {16'b0, got_r}, {16'b0, exp_d[15:0]});
                    check_output("idle_bits", {31'b0, extra}, 32'd0);
                    check_output("udf", {31'b0, udf}, {31'b0, udf_q.pop_front()});
                    check_output("ovr_count", ovr_seen, ovr_q.pop_front());
                end
                bit_idx  = 0;
                ovr_seen = 0;
            end
        end
    end

    // Present one pair so that the DUT samples it on clock edge t.
    task automatic drive_sample(input int t, input logic [15:0] l, input logic [15:0] r);
        if (edge_cnt > t - 1) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL stim_late: got edge %0d, expected <= %0d", edge_cnt, t - 1);
        end
        while (edge_cnt < t - 1) @(negedge clk);
        aud.lft_in  = l;
        aud.rht_in  = r;
        aud.aud_vld = 1'b1;
        @(negedge clk);
        aud.aud_vld = 1'b0;
    endtask

    // Window k covers the sample edges that feed boundary k. The boundary
    // transmits the last pair of the window; an empty window repeats the
    // previous frame (or mutes), and every extra pair is one overrun.
    task automatic apply_stimulus(input int k, input int cnt,
                                  input int o0, input logic [15:0] l0, input logic [15:0] r0,
                                  input int o1, input logic [15:0] l1, input logic [15:0] r1);
        int          base;
        logic [31:0] cur;
        base = FRAME_CLK * (k - 1);
        if (cnt >= 1) drive_sample(base + o0, l0, r0);
        if (cnt >= 2) drive_sample(base + o1, l1, r1);
        while (edge_cnt < base + 252) @(negedge clk);
        if (cnt == 1)      cur = {l0, r0};
        else if (cnt == 2) cur = {l1, r1};
`ifdef MUTE_ON_UDF_EN
        else if (k >= 2)   cur = 32'd0;
`endif
        else               cur = model_prev;
        data_q.push_back(cur);
        udf_q.push_back(cnt == 0 && k >= 2);
        ovr_q.push_back(cnt > 1 ? cnt - 1 : 0);
        model_prev = cur;
    endtask

    task automatic release_reset();
        data_q.delete();
        udf_q.delete();
        ovr_q.delete();
        model_prev = 32'd0;
        data_q.push_back(32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst         = 1'b1;
        aud.aud_vld = 1'b0;
        aud.lft_in  = '0;
        aud.rht_in  = '0;
        #1;
        check_output("rst_bclk", {31'b0, bclk}, 32'd0);
        check_output("rst_lrclk", {31'b0, lrclk}, 32'd0);
        check_output("rst_sdout", {31'b0, sdout}, 32'd0);
        repeat (3) @(negedge clk);
        release_reset();

        apply_stimulus(1, 1, 20, 16'hA5C3, 16'h8001, 0, 16'h0, 16'h0);
        apply_stimulus(2, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        apply_stimulus(3, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        apply_stimulus(4, 2, 30, 16'h1234, 16'h5678, 180, 16'h9ABC, 16'hDEF0);
        apply_stimulus(5, 1, 100, 16'h1111, 16'h2222, 0, 16'h0, 16'h0);
        apply_stimulus(6, 1, 0, 16'h7FFF, 16'h0001, 0, 16'h0, 16'h0);
        apply_stimulus(7, 1, 60, 16'hFFFF, 16'h0000, 0, 16'h0, 16'h0);
        for (int k = 8; k < 20; k++) begin
            apply_stimulus(k, int'($urandom_range(0, 2)),
                           int'($urandom_range(1, 120)), 16'($urandom), 16'($urandom),
                           int'($urandom_range(130, 250)), 16'($urandom), 16'($urandom));
        end
        apply_stimulus(20, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);

        // Reset in the middle of frame 20, at bit 40 of the right slot.
        base = FRAME_CLK * 20;
        while (edge_cnt < base + 162) @(negedge clk);
        check_output("pre_rst_bclk", {31'b0, bclk}, 32'd1);
        check_output("pre_rst_lrclk", {31'b0, lrclk}, 32'd1);
        check_output("frames_seen", data_q.size(), 32'd1);
        rst = 1'b1;
        #1;
        check_output("midrst_bclk", {31'b0, bclk}, 32'd0);
        check_output("midrst_lrclk", {31'b0, lrclk}, 32'd0);
        check_output("midrst_sdout", {31'b0, sdout}, 32'd0);
        check_output("midrst_frm", {31'b0, aud.frm_strt}, 32'd0);
        check_output("midrst_udf", {31'b0, udf}, 32'd0);
        check_output("midrst_ovr", {31'b0, ovr}, 32'd0);
        repeat (3) @(negedge clk);
        release_reset();

        while (edge_cnt < 2) @(negedge clk);
        check_output("restart_bclk_hi", {31'b0, bclk}, 32'd1);
        while (edge_cnt < 4) @(negedge clk);
        check_output("restart_bclk_fall", {31'b0, bclk}, 32'd0);
        check_output("restart_lrclk", {31'b0, lrclk}, 32'd0);

        apply_stimulus(1, 1, 40, 16'hFFFF, 16'h0000, 0, 16'h0, 16'h0);
        apply_stimulus(2, 1, 90, 16'($urandom), 16'($urandom), 0, 16'h0, 16'h0);
        apply_stimulus(3, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        while (edge_cnt < FRAME_CLK * 3 + 20) @(negedge clk);
        check_output("final_frames", data_q.size(), 32'd1);
        check_output("final_udf_q", udf_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
I2S transmitter that serialises signed 16-bit left/right audio samples to the codec DAC. It generates bit clock, word-select and serial data from the system clock. It sits downstream of the volume-scaling stage, accepting its registered lft/rht outputs qualified by aud_vld. Its frm_strt pulse paces upstream sample production.

Parameters:
BCLK_DIV, 4, clk cycles per bclk period; even, >=4
SLOT_BITS, 32, bclk cycles per channel slot; >=17
DATA_W, 16, sample width (fixed 16 in this release)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
aud_vld  input  1  1-clk strobe: lft_in/rht_in valid
lft_in  input  16  signed left sample
rht_in  input  16  signed right sample
frm_strt  output  1  1-clk pulse at frame boundary (frame regs loaded)
udf  output  1  1-clk pulse: frame boundary with no pending sample
ovr  output  1  1-clk pulse: pending sample overwritten before use
bclk  output  1  I2S bit clock
lrclk  output  1  I2S word select, 0=left, 1=right
sdout  output  1  I2S serial data, MSB first

Behaviour:
- Interface: one clock clk; reset rst asynchronous, active-high. All outputs registered.
- Reset: bclk=0, lrclk=0, sdout=0, frm_strt=0, udf=0, ovr=0; div_cnt=0, bit_cnt=0, pending and frame registers=0, pend_full=0. Assertion mid-frame forces outputs low immediately; after release, timing restarts at bit_cnt=0.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. bclk=1 while div_cnt in [BCLK_DIV/2, BCLK_DIV-1], else 0.
- "fall" event: the clk edge on which div_cnt wraps BCLK_DIV-1 -> 0. bclk falls, and bit_cnt, lrclk and sdout update, all on that same edge.
- bit_cnt counts 0..2*SLOT_BITS-1 on each fall and wraps.
- lrclk=0 for bit_cnt<SLOT_BITS, else 1.
- Slot position p = bit_cnt mod SLOT_BITS. sdout = sample[16-p] for 1<=p<=16 (I2S one-bclk delay, MSB at p=1), else 0. Sample = frame_lft when lrclk=0, frame_rht when lrclk=1.
- Input capture: aud_vld latches lft_in/rht_in into pending regs and sets pend_full.
- Overrun: aud_vld while pend_full=1 and no load on the same edge -> pending overwritten; ovr pulses.
- Frame boundary: the fall on which bit_cnt wraps 2*SLOT_BITS-1 -> 0. frm_strt pulses that cycle.
  - pend_full=1: frame regs <= pending; pend_full cleared.
  - pend_full=0: udf pulses; frame regs hold (last frame repeated).
- aud_vld coincident with boundary: frame loads the old pending; the new sample becomes pending (pend_full stays 1); no ovr.
- Frame 0 after reset transmits zeros and is not flagged udf. The first load occurs at the end of frame 0.
- Frame period = 2*SLOT_BITS*BCLK_DIV clk (256 at defaults).

Optional Feature:
MUTE_ON_UDF_EN
- Defined: an underflow boundary loads zeros into the frame regs (silence), and udf still pulses.
- Undefined: the frame regs hold and the last sample pair repeats.

Test Plan:
- Defaults. Reset, then aud_vld with lft=16'hA5C3, rht=16'h8001 during frame 0; sample sdout on bclk rise -> frame 1 left p1..16 = A5C3, right = 8001, all other bits 0; frm_strt every 256 clk; lrclk toggles every 128 clk.
- Send one pair, then none -> next boundary gives udf=1 and the pair repeats; frame 3 under MUTE_ON_UDF_EN gives all-zero sdout.
- Two aud_vld (1234/5678 then 9ABC/DEF0) within one frame -> ovr pulses once; next frame sends 9ABC/DEF0.
- aud_vld (7FFF/0001) in the same cycle as frm_strt while pending holds 1111/2222 -> 1111/2222 sent now, 7FFF/0001 next frame; no ovr, no udf.
- rst asserted at bit_cnt=40 -> all outputs 0 immediately; after release, first fall at clk 4, bit_cnt=1, lrclk=0, frame=0 (no udf at frame 0 end if sample given).
- Negative sample 16'hFFFF left, 16'h0000 right -> 16 ones then 15 zeros in the left slot, all-zero right slot.
